// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch, decode and per-opcode T-step strobes for the datapath.
// Latency: one T-step per clock; strobes decode from the registered state and IR (br T6 also uses CON).
// Backpressure: T1, ld T6 and st T7 hold while mem_ready is low; mem_timeout pulses on a long stall.
module control_sequencer #(
  parameter logic [4:0] ADD_OP       = 5'b00011,
  parameter int         MEM_WAIT_MAX = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        BAout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        Zin,
  output logic        MDRin,
  output logic        MARin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        IRin,
  output logic        OutPortin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        Run,
  output logic        illegal,
  output logic        mem_timeout
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int            CW          = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_MAX    = CW'(MEM_WAIT_MAX);
  localparam logic [CW-1:0] WAIT_MAX_M1 = CW'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          in_wait;
  logic [4:0]    op;
  logic          ir_unused;

  assign op        = IR[31:27];
  assign ir_unused = ^IR[26:0];

  // State register, memory-wait counter and the registered timeout pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_RESET;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_timeout <= in_wait && !mem_ready && (wait_cnt == WAIT_MAX_M1);
      if (!in_wait || mem_ready) wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Next-state and strobe decode for every T-step.
  always_comb begin
    state_nxt = state;
    in_wait   = 1'b0;
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout} = '0;
    {PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin} = '0;
    {Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write} = '0;
    alu_op  = 5'b00000;
    illegal = 1'b0;
    Run     = (state != ST_RESET) && (state != ST_HALT);
    case (state)
      ST_RESET: state_nxt = ST_T0;
      ST_T0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        state_nxt = ST_T1;
      end
      ST_T1: begin
        {Zlowout, PCin, Read, MDRin} = '1;
        in_wait = 1'b1;
        if (mem_ready) state_nxt = ST_T2;
      end
      ST_T2: begin
        {MDRout, IRin} = '1;
        if (op == OP_NOP)       state_nxt = ST_T0;
        else if (op == OP_HALT) state_nxt = ST_HALT;
        else                    state_nxt = ST_T3;
      end
      ST_T3: begin
        state_nxt = ST_T4;
        case (op)
          OP_LD, OP_LDI, OP_ST:                {Grb, BAout, Yin} = '1;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: {Grb, Rout, Yin} = '1;
          OP_BR:                               {Gra, Rout, CONin} = '1;
          OP_JR:   begin {Gra, Rout, PCin} = '1;      state_nxt = ST_T0; end
          OP_IN:   begin {InPortout, Gra, Rin} = '1;  state_nxt = ST_T0; end
          OP_OUT:  begin {Gra, Rout, OutPortin} = '1; state_nxt = ST_T0; end
          OP_MFHI: begin {HIout, Gra, Rin} = '1;      state_nxt = ST_T0; end
          OP_MFLO: begin {LOout, Gra, Rin} = '1;      state_nxt = ST_T0; end
          default: begin illegal = 1'b1;              state_nxt = ST_T0; end
        endcase
      end
      ST_T4: begin
        state_nxt = ST_T5;
        case (op)
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin {Cout, Zin} = '1; alu_op = ADD_OP; end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin {Grc, Rout, Zin} = '1; alu_op = op; end
          OP_BR:                               {PCout, Yin} = '1;
          default:                             state_nxt = ST_T0;
        endcase
      end
      ST_T5: begin
        state_nxt = ST_T0;
        case (op)
          OP_LD, OP_ST: begin {Zlowout, MARin} = '1; state_nxt = ST_T6; end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: {Zlowout, Gra, Rin} = '1;
          OP_BR: begin {Cout, Zin} = '1; alu_op = ADD_OP; state_nxt = ST_T6; end
          default: state_nxt = ST_T0;
        endcase
      end
      ST_T6: begin
        state_nxt = ST_T0;
        case (op)
          OP_LD: begin
            {Read, MDRin} = '1;
            in_wait   = 1'b1;
            state_nxt = mem_ready ? ST_T7 : ST_T6;
          end
          OP_ST: begin {Gra, Rout, MDRin} = '1; state_nxt = ST_T7; end
          // Branch taken only when the datapath CON flip-flop is set.
          OP_BR: if (CON) {Zlowout, PCin} = '1;
          default: state_nxt = ST_T0;
        endcase
      end
      ST_T7: begin
        state_nxt = ST_T0;
        case (op)
          OP_LD: {MDRout, Gra, Rin} = '1;
          OP_ST: begin
            Write     = 1'b1;
            in_wait   = 1'b1;
            state_nxt = mem_ready ? ST_T0 : ST_T7;
          end
          default: state_nxt = ST_T0;
        endcase
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: opcode vector table, directed corner sequences, random instruction stream.
// Latency: checks one sample per clock, 1 time unit after the rising edge.
// Backpressure: drives mem_ready stalls of random and fixed length on every memory wait step.
module tb_control_sequencer;

  localparam int         WMAX = 15;
  localparam logic [4:0] ADDC = 5'b00011;

  localparam logic [26:0] S_PCOUT     = 27'd1 << 26;
  localparam logic [26:0] S_ZLOWOUT   = 27'd1 << 24;
  localparam logic [26:0] S_MDROUT    = 27'd1 << 23;
  localparam logic [26:0] S_HIOUT     = 27'd1 << 22;
  localparam logic [26:0] S_LOOUT     = 27'd1 << 21;
  localparam logic [26:0] S_BAOUT     = 27'd1 << 20;
  localparam logic [26:0] S_INPORTOUT = 27'd1 << 19;
  localparam logic [26:0] S_COUT      = 27'd1 << 18;
  localparam logic [26:0] S_PCIN      = 27'd1 << 17;
  localparam logic [26:0] S_ZIN       = 27'd1 << 16;
  localparam logic [26:0] S_MDRIN     = 27'd1 << 15;
  localparam logic [26:0] S_MARIN     = 27'd1 << 14;
  localparam logic [26:0] S_YIN       = 27'd1 << 13;
  localparam logic [26:0] S_IRIN      = 27'd1 << 10;
  localparam logic [26:0] S_OUTPORTIN = 27'd1 << 9;
  localparam logic [26:0] S_CONIN     = 27'd1 << 8;
  localparam logic [26:0] S_GRA       = 27'd1 << 7;
  localparam logic [26:0] S_GRB       = 27'd1 << 6;
  localparam logic [26:0] S_GRC       = 27'd1 << 5;
  localparam logic [26:0] S_RIN       = 27'd1 << 4;
  localparam logic [26:0] S_ROUT      = 27'd1 << 3;
  localparam logic [26:0] S_INCPC     = 27'd1 << 2;
  localparam logic [26:0] S_READ      = 27'd1 << 1;
  localparam logic [26:0] S_WRITE     = 27'd1;
  localparam logic [26:0] T0PAT       = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;

  logic        Clock, Reset, CON, mem_ready;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout;
  logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run, illegal, mem_timeout;
  logic [4:0]  alu_op;
  logic [26:0] strb;

  assign strb = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
                 PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin,
                 Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write};

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .mem_ready(mem_ready),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .BAout(BAout), .InPortout(InPortout), .Cout(Cout), .PCin(PCin), .Zin(Zin),
    .MDRin(MDRin), .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .IRin(IRin),
    .OutPortin(OutPortin), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int to_pulses = 0;

  typedef struct {
    logic [26:0] s;
    logic [4:0]  alu;
    bit          w;
    bit          ill;
  } step_t;
  step_t plan_q[$];

  typedef struct {
    logic [4:0]  op;
    logic        con;
    int          lat;
    logic [26:0] t3;
    logic [4:0]  a4;
    logic        ill;
  } vec_t;
  vec_t tbl[17];

  logic [4:0] rops[18];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full output vector against expectation; also tallies timeout pulses seen.
  task automatic check(input string nm, input logic [26:0] es, input logic [4:0] ea,
                       input logic er, input logic ei, input logic et);
    cmp(nm, 64'({strb, alu_op, Run, illegal, mem_timeout}), 64'({es, ea, er, ei, et}));
    if (mem_timeout) to_pulses++;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [26:0] s, input logic [4:0] a, input bit w, input bit ill);
    plan_q.push_back('{s, a, w, ill});
  endtask

  // Reference: the list of T-steps an instruction should walk through.
  task automatic plan(input logic [4:0] op, input logic con);
    plan_q.delete();
    push(T0PAT, 5'd0, 1'b0, 1'b0);
    push(S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 5'd0, 1'b1, 1'b0);
    push(S_MDROUT | S_IRIN, 5'd0, 1'b0, 1'b0);
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        push(S_GRB | S_BAOUT | S_YIN, 5'd0, 1'b0, 1'b0);
        push(S_COUT | S_ZIN, ADDC, 1'b0, 1'b0);
        if (op == 5'b00001) push(S_ZLOWOUT | S_GRA | S_RIN, 5'd0, 1'b0, 1'b0);
        else push(S_ZLOWOUT | S_MARIN, 5'd0, 1'b0, 1'b0);
        if (op == 5'b00000) begin
          push(S_READ | S_MDRIN, 5'd0, 1'b1, 1'b0);
          push(S_MDROUT | S_GRA | S_RIN, 5'd0, 1'b0, 1'b0);
        end
        if (op == 5'b00010) begin
          push(S_GRA | S_ROUT | S_MDRIN, 5'd0, 1'b0, 1'b0);
          push(S_WRITE, 5'd0, 1'b1, 1'b0);
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b0, 1'b0);
        push(S_GRC | S_ROUT | S_ZIN, op, 1'b0, 1'b0);
        push(S_ZLOWOUT | S_GRA | S_RIN, 5'd0, 1'b0, 1'b0);
      end
      5'b01100: begin
        push(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b0, 1'b0);
        push(S_COUT | S_ZIN, ADDC, 1'b0, 1'b0);
        push(S_ZLOWOUT | S_GRA | S_RIN, 5'd0, 1'b0, 1'b0);
      end
      5'b10011: begin
        push(S_GRA | S_ROUT | S_CONIN, 5'd0, 1'b0, 1'b0);
        push(S_PCOUT | S_YIN, 5'd0, 1'b0, 1'b0);
        push(S_COUT | S_ZIN, ADDC, 1'b0, 1'b0);
        push(con ? (S_ZLOWOUT | S_PCIN) : 27'd0, 5'd0, 1'b0, 1'b0);
      end
      5'b10100: push(S_GRA | S_ROUT | S_PCIN, 5'd0, 1'b0, 1'b0);
      5'b10110: push(S_INPORTOUT | S_GRA | S_RIN, 5'd0, 1'b0, 1'b0);
      5'b10111: push(S_GRA | S_ROUT | S_OUTPORTIN, 5'd0, 1'b0, 1'b0);
      5'b11000: push(S_HIOUT | S_GRA | S_RIN, 5'd0, 1'b0, 1'b0);
      5'b11001: push(S_LOOUT | S_GRA | S_RIN, 5'd0, 1'b0, 1'b0);
      5'b11010, 5'b11011: ;
      default: push(27'd0, 5'd0, 1'b0, 1'b1);
    endcase
  endtask

  function automatic int rand_stalls();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(13, 17));
    return int'($urandom_range(0, 3));
  endfunction

  // Runs one instruction from T0 against the step plan; negative stall counts pick randomly.
  task automatic exec_instr(input logic [4:0] op, input logic con, input int s_fetch, input int s_mem);
    int target, st;
    bit adv;
    plan(op, con);
    IR  = {op, 27'($urandom)};
    CON = con;
    foreach (plan_q[i]) begin
      target = 0;
      if (plan_q[i].w) begin
        target = (i == 1) ? s_fetch : s_mem;
        if (target < 0) target = rand_stalls();
      end
      st  = 0;
      adv = 1'b0;
      while (!adv) begin
        mem_ready = plan_q[i].w ? (st >= target) : 1'($urandom);
        check($sformatf("op%b_step%0d_wait%0d", op, i, st), plan_q[i].s, plan_q[i].alu, 1'b1,
              plan_q[i].ill, plan_q[i].w && (st == WMAX));
        adv = !(plan_q[i].w && !mem_ready);
        tick();
        st++;
      end
    end
  endtask

  task automatic do_reset(input string nm);
    Reset = 1'b1;
    tick();
    check({nm, "_rst1"}, 27'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check({nm, "_rst2"}, 27'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick();
    check({nm, "_t0"}, T0PAT, 5'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic resync(input string nm);
    bit found;
    found = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (Run && strb == T0PAT) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    cmp({nm, "_back_to_t0"}, 64'(found), 64'd1);
  endtask

  initial begin
    int lat;
    logic [26:0] got_t3;
    logic [4:0]  got_a4;
    logic        got_ill;
    logic [4:0]  rop;

    // opcode, CON, latency, T3 strobes, T4 alu_op, illegal in T3
    tbl[0]  = '{5'b00000, 1'b0, 8, S_GRB | S_BAOUT | S_YIN, ADDC, 1'b0};
    tbl[1]  = '{5'b00001, 1'b0, 6, S_GRB | S_BAOUT | S_YIN, ADDC, 1'b0};
    tbl[2]  = '{5'b00010, 1'b0, 8, S_GRB | S_BAOUT | S_YIN, ADDC, 1'b0};
    tbl[3]  = '{5'b00011, 1'b0, 6, S_GRB | S_ROUT | S_YIN, 5'b00011, 1'b0};
    tbl[4]  = '{5'b00100, 1'b0, 6, S_GRB | S_ROUT | S_YIN, 5'b00100, 1'b0};
    tbl[5]  = '{5'b00101, 1'b1, 6, S_GRB | S_ROUT | S_YIN, 5'b00101, 1'b0};
    tbl[6]  = '{5'b00110, 1'b0, 6, S_GRB | S_ROUT | S_YIN, 5'b00110, 1'b0};
    tbl[7]  = '{5'b01100, 1'b0, 6, S_GRB | S_ROUT | S_YIN, ADDC, 1'b0};
    tbl[8]  = '{5'b10011, 1'b1, 7, S_GRA | S_ROUT | S_CONIN, 5'd0, 1'b0};
    tbl[9]  = '{5'b10011, 1'b0, 7, S_GRA | S_ROUT | S_CONIN, 5'd0, 1'b0};
    tbl[10] = '{5'b10100, 1'b0, 4, S_GRA | S_ROUT | S_PCIN, 5'd0, 1'b0};
    tbl[11] = '{5'b10110, 1'b0, 4, S_INPORTOUT | S_GRA | S_RIN, 5'd0, 1'b0};
    tbl[12] = '{5'b10111, 1'b0, 4, S_GRA | S_ROUT | S_OUTPORTIN, 5'd0, 1'b0};
    tbl[13] = '{5'b11000, 1'b0, 4, S_HIOUT | S_GRA | S_RIN, 5'd0, 1'b0};
    tbl[14] = '{5'b11001, 1'b0, 4, S_LOOUT | S_GRA | S_RIN, 5'd0, 1'b0};
    tbl[15] = '{5'b11010, 1'b0, 3, T0PAT, 5'd0, 1'b0};
    tbl[16] = '{5'b11111, 1'b0, 4, 27'd0, 5'd0, 1'b1};

    rops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
             5'b10011, 5'b10100, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11010,
             5'b11111, 5'b01000, 5'b11100};

    Reset = 1'b1; CON = 1'b0; mem_ready = 1'b0; IR = 32'h1800_0000;
    do_reset("init");

    // Fetch stall: T1 held for three low cycles plus the ready cycle.
    mem_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      check($sformatf("fetch_hold%0d", k), S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("fetch_t2", S_MDROUT | S_IRIN, 5'd0, 1'b1, 1'b0, 1'b0);
    resync("fetch");

    // Vector table: latency, T3 decode, T4 ALU code, illegal flag.
    for (int v = 0; v < 17; v++) begin
      lat = 0; got_t3 = '0; got_a4 = '0; got_ill = 1'b0;
      IR = {tbl[v].op, 27'($urandom)}; CON = tbl[v].con; mem_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (c == 3) begin got_t3 = strb; got_ill = illegal; end
        if (c == 4) got_a4 = alu_op;
        tick();
        if (lat == 0 && Run && strb == T0PAT) lat = c + 1;
        if (lat != 0 && c >= 4) break;
      end
      cmp($sformatf("tbl%0d_latency", v), 64'(lat), 64'(tbl[v].lat));
      cmp($sformatf("tbl%0d_t3", v), 64'(got_t3), 64'(tbl[v].t3));
      cmp($sformatf("tbl%0d_t4_alu", v), 64'(got_a4), 64'(tbl[v].a4));
      cmp($sformatf("tbl%0d_illegal", v), 64'(got_ill), 64'(tbl[v].ill));
      resync($sformatf("tbl%0d", v));
    end

    // Directed instructions through the step model.
    exec_instr(5'b00100, 1'b0, 0, 0);
    exec_instr(5'b10011, 1'b1, 0, 0);
    exec_instr(5'b10011, 1'b0, 1, 0);
    to_pulses = 0;
    exec_instr(5'b00000, 1'b0, 0, 16);
    cmp("ld_timeout_pulses", 64'(to_pulses), 64'd1);
    exec_instr(5'b00010, 1'b0, 15, 14);
    exec_instr(5'b11111, 1'b1, 0, 0);

    // Random instruction stream with random stalls.
    for (int n = 0; n < 250; n++) begin
      rop = rops[$urandom_range(0, 17)];
      exec_instr(rop, 1'($urandom), -1, -1);
    end
    check("random_end_t0", T0PAT, 5'd0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an st write wait.
    IR = {5'b00010, 27'h0}; CON = 1'b0; mem_ready = 1'b1;
    repeat (7) tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("st_write_hold%0d", k), S_WRITE, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    do_reset("st_abort");

    // Halt: Run drops and stays low until reset.
    exec_instr(5'b11011, 1'b0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom);
      check($sformatf("halt%0d", k), 27'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    do_reset("halt_exit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the datapath control strobes: fetch, decode, then a fixed per-opcode T-step sequence, one step per clock.
- It replaces hand-timed testbench stimulus: it produces the same strobe names the datapath already accepts, plus `alu_op`.
- Opcode is taken from `IR[31:27]`.
- Sits beside `datapath`; `CON` comes from the datapath CON flip-flop; `mem_ready` comes from memory.

Parameters:
- ADD_OP, 5'b00011, ALU code driven for address and branch-target adds.
- MEM_WAIT_MAX, 15, stall cycles tolerated before `mem_timeout` pulses (the stall itself continues).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- IR  in  32  instruction register; bits [31:27] are the opcode.
- CON  in  1  branch condition, valid from T4 onward.
- mem_ready  in  1  memory completed the current Read/Write.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout  out  1 each  bus drivers.
- PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin  out  1 each  register loads.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select and strobes.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- alu_op  out  5  ALU function; 0 unless Zin is high.
- Run  out  1  1 while executing; 0 in HALT.
- illegal  out  1  one-cycle pulse on an undecoded opcode.
- mem_timeout  out  1  one-cycle pulse when a memory wait reaches MEM_WAIT_MAX.

Behaviour:
- State register: RESET, T0..T7, HALT.
- Outputs are decoded from the registered state and IR only, never from inputs, except that T6 of br also uses CON.
- Every strobe not listed for a step is 0.
- Reset has priority in every state, including mid-instruction and HALT.
  - Next state is RESET; all outputs 0; Run=0; wait counter cleared.
  - RESET goes to T0 on the following cycle, with Run=1.
- Fetch, common to all opcodes:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold T1 while mem_ready=0, repeating the same strobes.
  - T2: MDRout, IRin.
- Decode happens in T3 from the newly loaded IR. Per-opcode steps:
  - ld 00000: T3 Grb BAout Yin; T4 Cout Zin alu_op=ADD_OP; T5 Zlowout MARin; T6 Read MDRin, held until mem_ready; T7 MDRout Gra Rin.
  - ldi 00001: T3 and T4 as ld; T5 Zlowout Gra Rin.
  - st 00010: T3–T5 as ld; T6 Gra Rout MDRin; T7 Write, held until mem_ready.
  - add 00011, sub 00100, and 00101, or 00110: T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=opcode; T5 Zlowout Gra Rin.
  - addi 01100: T3 Grb Rout Yin; T4 Cout Zin alu_op=ADD_OP; T5 Zlowout Gra Rin.
  - br 10011: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin alu_op=ADD_OP; T6 Zlowout and PCin only if CON=1, otherwise an idle step.
  - jr 10100: T3 Gra Rout PCin.
  - in 10110: T3 InPortout Gra Rin.
  - out 10111: T3 Gra Rout OutPortin.
  - mfhi 11000: T3 HIout Gra Rin.
  - mflo 11001: T3 LOout Gra Rin.
  - nop 11010: no execute steps; T2 goes directly to T0.
  - halt 11011: T2 goes to HALT. HALT holds Run=0 and all strobes 0; it is exited only by Reset.
  - Any other opcode: `illegal` pulses in T3, then treated as nop (T3 goes to T0).
- After the last step of any instruction, the next state is T0.
- Memory waits (T1, ld T6, st T7):
  - A counter increments on each cycle of the wait.
  - `mem_timeout` pulses once when the counter reaches MEM_WAIT_MAX; the counter saturates and the state keeps waiting.
  - The counter clears when the step advances.
- If mem_ready is already 1 on the first cycle of a wait step, that step lasts exactly one cycle.
- Instruction latency with no waits:
  - nop: 3 cycles.
  - jr, in, out, mfhi, mflo: 4 cycles.
  - ldi and ALU ops: 6 cycles.
  - br: 7 cycles.
  - ld, st: 8 cycles.

Test Plan:
- Reset high 2 cycles, then low, IR=add (0x18000000 family) -> RESET, then T0 with Run=1; all strobes 0 during reset; T0 shows PCout=MARin=IncPC=Zin=1.
- Fetch with mem_ready low 3 cycles -> T1 strobes held exactly 4 cycles, then T2 MDRout=IRin=1; mem_timeout stays 0.
- IR opcode 00100 (sub) -> T4 has Grc=Rout=Zin=1 and alu_op=5'b00100; T5 has Zlowout=Gra=Rin=1; next fetch 6 cycles after T0.
- br with CON=1 -> T6 Zlowout=PCin=1; same instruction with CON=0 -> T6 has all strobes 0; both return to T0.
- ld with mem_ready held low 16 cycles in T6 -> mem_timeout pulses once at wait cycle 15; T7 Gra=Rin=MDRout=1 after mem_ready rises.
- IR opcode 11111 -> illegal pulses 1 cycle in T3, then T0. halt -> Run=0 and stays HALT for 20 cycles. Reset asserted in the middle of an st T7 wait -> Write drops in the next cycle and the sequencer restarts at T0.
